// File: rtl/npu_shift_pkg.sv
// Shared helpers for the NPU shift datapaths (left-shift restore and
// right-shift requant): lossless width derivation and saturating clip.
package npu_shift_pkg;

    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_MAX_W-1:0] data;
    } sat_res_t;

    function automatic int full_width(input int in_w, input int s_w);
        return in_w + (1 << s_w) - 1;
    endfunction

    // Clip a wide signed value into a signed field of the given width.
    function automatic sat_res_t sat_clip(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] lim;
        sat_res_t                    r;
        lim   = 64'sd1 <<< (width - 1);
        r.sat = 1'b1;
        if (value > lim - 64'sd1) begin
            r.data = lim - 64'sd1;
        end else if (value < -lim) begin
            r.data = -lim;
        end else begin
            r.data = value;
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/left_shifter.sv
// Sign-extend then shift left; the intermediate is wide enough to be exact.
module left_shifter #(
    parameter int IN_WIDTH   = 10,
    parameter int IN_S_WIDTH = 3,
    parameter int FULL_WIDTH = 17
) (
    input  logic signed [IN_WIDTH-1:0]   i_data,
    input  logic        [IN_S_WIDTH-1:0] i_shift,
    output logic signed [FULL_WIDTH-1:0] o_full
);

    assign o_full = FULL_WIDTH'(i_data) <<< i_shift;

endmodule

// File: rtl/left_shift_sat_pipe.sv
// Two-stage streaming signed left shifter with output saturation and a
// sticky count of clipped beats delivered downstream.
module left_shift_sat_pipe
    import npu_shift_pkg::*;
#(
    parameter int IN_WIDTH   = 10,
    parameter int IN_S_WIDTH = 3,
    parameter int OUT_WIDTH  = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic [IN_S_WIDTH-1:0]       i_shift_value,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_sat,
    input  logic                        i_sat_clr,
    output logic [CNT_WIDTH-1:0]        o_sat_cnt
);

    localparam int FULL_WIDTH = full_width(IN_WIDTH, IN_S_WIDTH);

    logic                         w_adv1;
    logic                         w_adv2;
    logic                         w_xfer_sat;
    logic signed [FULL_WIDTH-1:0] w_full;
    sat_res_t                     w_clip;
    logic                         r_s1_valid;
    logic signed [FULL_WIDTH-1:0] r_s1_full;

    left_shifter #(
        .IN_WIDTH   (IN_WIDTH),
        .IN_S_WIDTH (IN_S_WIDTH),
        .FULL_WIDTH (FULL_WIDTH)
    ) u_shl (
        .i_data  (i_data),
        .i_shift (i_shift_value),
        .o_full  (w_full)
    );

    assign w_adv2     = !o_valid || i_ready;
    assign w_adv1     = !r_s1_valid || w_adv2;
    assign o_ready    = w_adv1;
    assign w_clip     = sat_clip(SAT_MAX_W'(r_s1_full), OUT_WIDTH);
    assign w_xfer_sat = o_valid && i_ready && o_sat;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_full  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_full <= w_full;
            end
        end
    end

    // Output holds its beat while the consumer stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else if (w_adv2) begin
            o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_data <= w_clip.data[OUT_WIDTH-1:0];
                o_sat  <= w_clip.sat;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (w_xfer_sat && (o_sat_cnt != {CNT_WIDTH{1'b1}})) begin
            o_sat_cnt <= o_sat_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_left_shift_sat_pipe.sv
// Bench for left_shift_sat_pipe: directed boundary cases plus random
// traffic checked against a queue-based arithmetic model.
module tb_left_shift_sat_pipe;

    localparam int IW = 10;
    localparam int SW = 3;
    localparam int OW = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          rdy_in = 1'b1;
    logic          sat_clr = 1'b0;
    logic [IW-1:0] din = '0;
    logic [SW-1:0] sh = '0;
    logic          o_ready;
    logic          o_valid;
    logic [OW-1:0] o_data;
    logic          o_sat;
    logic [CW-1:0] o_sat_cnt;
    logic          o_ready2;
    logic          o_valid2;
    logic [OW-1:0] o_data2;
    logic          o_sat2;
    logic [1:0]    cnt2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        longint d;
        bit     sat;
        int     acc;
    } beat_t;

    beat_t  q[$];
    longint mcnt = 0;
    longint mcnt2 = 0;
    int     edge_cnt = 0;
    bit     s_in = 0;
    bit     s_out = 0;
    bit     s_clr = 0;
    logic [IW-1:0] s_din;
    logic [SW-1:0] s_sh;

    left_shift_sat_pipe #(
        .IN_WIDTH(IW), .IN_S_WIDTH(SW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready),
        .i_data(din), .i_shift_value(sh), .o_valid(o_valid),
        .i_ready(rdy_in), .o_data(o_data), .o_sat(o_sat),
        .i_sat_clr(sat_clr), .o_sat_cnt(o_sat_cnt)
    );

    left_shift_sat_pipe #(
        .IN_WIDTH(IW), .IN_S_WIDTH(SW), .OUT_WIDTH(OW), .CNT_WIDTH(2)
    ) dut2 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(o_ready2),
        .i_data(din), .i_shift_value(sh), .o_valid(o_valid2),
        .i_ready(rdy_in), .o_data(o_data2), .o_sat(o_sat2),
        .i_sat_clr(sat_clr), .o_sat_cnt(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Exact product then clip to the signed output range.
    function automatic longint ref_val(input longint d, input int s, output bit sat);
        longint full;
        longint mx;
        longint mn;
        full = d * (64'sd1 << s);
        mx   = (64'sd1 << (OW - 1)) - 1;
        mn   = -(mx + 1);
        sat  = 1'b1;
        if (full > mx) return mx;
        if (full < mn) return mn;
        sat = 1'b0;
        return full;
    endfunction

    function automatic longint sdata(input logic [OW-1:0] v);
        return longint'($signed(v));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst o_valid", longint'(o_valid), 0);
            chk("rst o_data", sdata(o_data), 0);
            chk("rst o_sat", longint'(o_sat), 0);
            chk("rst o_sat_cnt", longint'(o_sat_cnt), 0);
        end else begin
            chk("o_valid", longint'(o_valid),
                longint'(q.size() > 0 && q[0].acc < edge_cnt));
            if (o_valid && q.size() > 0) begin
                chk("o_data", sdata(o_data), q[0].d);
                chk("o_sat", longint'(o_sat), longint'(q[0].sat));
            end
            chk("o_ready", longint'(o_ready), longint'(q.size() < 2 || rdy_in));
            chk("o_sat_cnt", longint'(o_sat_cnt), mcnt);
            chk("o_sat_cnt w2", longint'(cnt2), mcnt2);
        end
        s_in  = valid && o_ready;
        s_out = o_valid && rdy_in;
        s_clr = sat_clr;
        s_din = din;
        s_sh  = sh;
    end

    always @(posedge clk or posedge rst) begin
        beat_t e;
        bit    b;
        if (rst) begin
            q.delete();
            mcnt  = 0;
            mcnt2 = 0;
            s_in  = 0;
            s_out = 0;
            s_clr = 0;
        end else begin
            edge_cnt++;
            b = 0;
            if (s_out && q.size() > 0) begin
                e = q.pop_front();
                b = e.sat;
            end
            if (s_clr) begin
                mcnt  = 0;
                mcnt2 = 0;
            end else if (b) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
            if (s_in) begin
                e.d   = ref_val(longint'($signed(s_din)), int'(s_sh), e.sat);
                e.acc = edge_cnt;
                q.push_back(e);
            end
        end
    end

    task automatic send_chk(input int d, input int s, input longint ed, input int es);
        @(posedge clk); #1;
        valid = 1; din = IW'(d); sh = SW'(s);
        @(posedge clk); #1;
        valid = 0;
        @(negedge clk);
        chk("lat1 o_valid", longint'(o_valid), 0);
        @(negedge clk);
        chk("lat2 o_valid", longint'(o_valid), 1);
        chk("dir o_data", sdata(o_data), ed);
        chk("dir o_sat", longint'(o_sat), longint'(es));
    endtask

    initial begin
        bit b;
        chk("pin 3<<2", ref_val(3, 2, b), 12);
        chk("pin 128<<7", ref_val(128, 7, b), 16383);
        chk("pin -129<<7", ref_val(-129, 7, b), -16384);
        chk("pin -1<<7", ref_val(-1, 7, b), -128);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post-rst o_ready", longint'(o_ready), 1);

        send_chk(3, 2, 12, 0);
        send_chk(127, 7, 16256, 0);
        send_chk(128, 7, 16383, 1);
        send_chk(511, 7, 16383, 1);
        send_chk(-128, 7, -16384, 0);
        send_chk(-129, 7, -16384, 1);
        send_chk(-1, 7, -128, 0);
        send_chk(-5, 0, -5, 0);

        // backpressure: three beats with the consumer stalled
        @(posedge clk); #1;
        rdy_in = 0; valid = 1; din = 1; sh = 0;
        @(posedge clk); #1 din = 2;
        @(posedge clk); #1 din = 3;
        @(negedge clk);
        chk("bp o_ready", longint'(o_ready), 0);
        chk("bp hold", sdata(o_data), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp hold late", sdata(o_data), 1);
        @(posedge clk); #1 rdy_in = 1;
        @(negedge clk);
        chk("bp out1", sdata(o_data), 1);
        @(posedge clk); #1 valid = 0;
        @(negedge clk);
        chk("bp out2", sdata(o_data), 2);
        chk("bp out2 v", longint'(o_valid), 1);
        @(negedge clk);
        chk("bp out3", sdata(o_data), 3);
        chk("bp out3 v", longint'(o_valid), 1);

        // counter: clear, 5 saturating, then clear colliding with a 6th
        @(posedge clk); #1 sat_clr = 1;
        @(posedge clk); #1 sat_clr = 0;
        repeat (5) send_chk(200, 7, 16383, 1);
        @(negedge clk);
        chk("cnt five", longint'(o_sat_cnt), 5);
        chk("cnt2 sticky", longint'(cnt2), 3);
        @(posedge clk); #1;
        valid = 1; din = 300; sh = 6;
        @(posedge clk); #1 valid = 0;
        @(posedge clk); #1 sat_clr = 1;
        @(negedge clk);
        chk("clr race o_valid", longint'(o_valid), 1);
        @(posedge clk); #1 sat_clr = 0;
        @(negedge clk);
        chk("clr wins", longint'(o_sat_cnt), 0);
        repeat (4) send_chk(-300, 7, -16384, 1);
        @(negedge clk);
        chk("cnt four", longint'(o_sat_cnt), 4);
        chk("cnt2 four", longint'(cnt2), 3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            valid   = ($urandom_range(0, 3) != 0);
            rdy_in  = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 63) == 0);
            din     = IW'($urandom);
            sh      = SW'($urandom);
        end

        // reset with two beats in flight
        @(posedge clk); #1;
        sat_clr = 0; rdy_in = 0; valid = 1; din = 400; sh = 7;
        repeat (2) @(posedge clk);
        #1 valid = 0;
        #2 rst = 1;
        #1;
        chk("async o_valid", longint'(o_valid), 0);
        chk("async cnt", longint'(o_sat_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0; rdy_in = 1;
        @(negedge clk);
        chk("rel o_ready", longint'(o_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("no stale", longint'(o_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/left_shift_sat_pipe.md
Name: left_shift_sat_pipe

Overview:
Streaming signed left shifter with saturation. It restores scale in the direction opposite to the arithmetic right shifter used for requantization, for example when re-aligning partial sums or bias terms to an accumulator format. It is a 2-stage valid/ready pipeline with full backpressure and a sticky saturation-event counter for debug and quantization tuning.

Parameters:
IN_WIDTH, 10, signed input data width
IN_S_WIDTH, 3, shift-amount width; max shift = 2^IN_S_WIDTH-1
OUT_WIDTH, 15, signed output width; result clipped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
CNT_WIDTH, 16, saturation-event counter width
FULL_WIDTH, IN_WIDTH+2^IN_S_WIDTH-1 (derived, localparam), lossless intermediate width

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous active-high reset
i_valid  input  1  input beat valid
o_ready  output  1  block can accept a beat this cycle
i_data  input  IN_WIDTH  signed operand
i_shift_value  input  IN_S_WIDTH  unsigned left-shift amount
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts output beat
o_data  output  OUT_WIDTH  signed shifted, saturated result
o_sat  output  1  this output beat was clipped
i_sat_clr  input  1  synchronous clear of o_sat_cnt
o_sat_cnt  output  CNT_WIDTH  number of clipped beats delivered, sticky at all-ones

Behaviour:
- Clock and reset are decided: one clock i_clk; i_reset is asynchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_sat=0, o_sat_cnt=0, internal stage-1 valid=0. o_ready is 1 as soon as reset is released.
- Handshakes:
  - Input transfer on i_valid&&o_ready.
  - Output transfer on o_valid&&i_ready.
  - o_data and o_sat stay stable while o_valid&&!i_ready.
- Pipeline control:
  - adv2 = !o_valid || i_ready.
  - adv1 = !s1_valid || adv2.
  - o_ready = adv1 (combinational from i_ready; this path is accepted).
- Stage 1 (on accept): register full = sext(i_data, FULL_WIDTH) << i_shift_value. The value is exact and cannot overflow.
- Stage 2 (on adv2): from stage 1:
  - full > 2^(OUT_WIDTH-1)-1 -> o_data = max positive, o_sat = 1.
  - full < -2^(OUT_WIDTH-1) -> o_data = min negative, o_sat = 1.
  - else o_data = full[OUT_WIDTH-1:0], o_sat = 0.
  - o_valid <= s1_valid.
- Latency: 2 cycles from input accept to o_valid with no stall. Throughput is 1 beat/cycle.
- Capacity: 2 beats in flight. With i_ready held low, o_ready drops after 2 accepted beats and no beat is lost or duplicated.
- Shift 0: passes i_data sign-extended to OUT_WIDTH. No saturation is possible when IN_WIDTH<=OUT_WIDTH.
- Counter:
  - Increments on each output transfer with o_sat=1.
  - Holds at all-ones and does not wrap.
  - i_sat_clr sets it to 0 next cycle. Clear wins over an increment in the same cycle, and that increment is dropped.
- Reset mid-operation: all in-flight beats are discarded and the counter returns to 0.
- Simultaneous stage-2 drain and stage-1 refill in the same cycle keep full throughput.

Decomposition:
- Shared package npu_shift_pkg:
  - saturating-clip function sat_clip(value, width) returning data and flag.
  - FULL_WIDTH derivation.
  - Both are reused by the right-shift requant path.
- Natural combinational sub-module: left_shifter (IN_WIDTH, IN_S_WIDTH, FULL_WIDTH). It performs the sign-extend-and-shift only, as the mirror of the existing right-shift unit, and is instantiated in stage 1.

Test Plan:
- i_data=3, shift=2, i_ready=1 -> o_data=12, o_sat=0, o_valid exactly 2 cycles after accept.
- Saturation boundary, positive: i_data=127, shift=7 -> 16256, o_sat=0; i_data=128, shift=7 -> 16383, o_sat=1; i_data=511, shift=7 -> 16383, o_sat=1.
- Saturation boundary, negative: i_data=-128, shift=7 -> -16384, o_sat=0; i_data=-129, shift=7 -> -16384, o_sat=1; i_data=-1, shift=7 -> -128, o_sat=0.
- Backpressure: i_ready=0, i_valid=1 with beats 1,2,3 (shift 0) -> o_ready falls after 2 accepts and o_data holds 1. Release i_ready -> outputs 1,2,3 in order, no gaps once flowing.
- Counter: 5 saturating beats -> o_sat_cnt=5; assert i_sat_clr on the same cycle as a 6th saturating transfer -> o_sat_cnt=0. With CNT_WIDTH forced to 2, 4 saturating beats -> o_sat_cnt=3 (sticky).
- Reset mid-stream: assert i_reset with 2 beats in flight -> o_valid=0 and o_sat_cnt=0 immediately (async); after release o_ready=1 and no stale beat appears.
